dpram_port_arbiter: RTL and testbench

- Shares one port of a dual-port video/object RAM among NUM_REQ requesters, e.g. CPU, sprite DMA and line renderer. The RAM's other port is left to a free-running consumer.
- Arbitration is round-robin. Grants are one access per cycle, and read data returns one cycle after the grant.
- A built-in clear sequencer fills the whole RAM with CLEAR_VAL on command. Requesters are stalled while it runs.

---
 rtl/dpram_port_arbiter_pkg.sv | 37 +++
 rtl/dpram_port_arbiter_rr_arbiter.sv | 50 +++++
 rtl/dpram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_dpram_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_port_arbiter_pkg.sv
// rtl/dpram_port_arbiter_pkg.sv - shared state codes and round-robin pick helper
//
// Purpose: common definitions for the DPRAM port arbiter.
//   - arb_state_t : arbiter FSM state (IDLE arbitrates, CLEAR fills the RAM)
//   - rr_pick     : round-robin winner index for up to 8 requesters
package dpram_port_arbiter_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 1'b0;
  localparam arb_state_t ST_CLEAR = 1'b1;

  // Index width fixed at 3 bits so one helper serves every NUM_REQ in 2..8.
  // Search starts just after last and wraps modulo n; the first set bit wins.
  // With no request the returned index is last, so downstream muxes keep
  // presenting the previous winner's address/data.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && !found) begin
        idx = (int'(last) + k) % n;
        if (req[idx[2:0]]) begin
          win   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// rtl/dpram_port_arbiter_rr_arbiter.sv - round-robin pick with registered last-grant pointer
//
// Purpose: combinational one-hot grant among NUM_REQ requesters, rotating
// priority from the last granted requester.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   en             : grant enable; with en low no grant and pointer holds
//   req            : per-requester request bits
//   gnt            : one-hot grant (zero when en low or no request)
//   win_idx        : winning index (last grant when nothing requested)
module dpram_port_arbiter_rr_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         win_idx
);

  logic [2:0] last_grant_q;
  logic [2:0] last_grant_d;
  logic [7:0] req_pad;
  logic       any_req;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req;
    any_req                = |req;
    win_idx                = rr_pick(req_pad, last_grant_q, NUM_REQ);
    gnt                    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = en && any_req && (win_idx == 3'(i));
    end
    last_grant_d = (en && any_req) ? win_idx : last_grant_q;
  end

  // Pointer starts at the highest index so requester 0 is searched first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 3'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin sharing of one DPRAM port with a clear sequencer
//
// Purpose: grants one requester per cycle onto a single RAM port, returns
// read data one cycle later, and can fill the whole RAM with CLEAR_VAL.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   req/we/addr/wdata       : per-requester access (addr/wdata packed by index)
//   ack                     : combinational one-hot grant
//   rvalid, rdata           : registered read-return strobe, shared read data
//   clear_start, clear_busy : clear command pulse, clear-in-progress flag
//   ram_wren/address/data   : to the RAM port; ram_q from the RAM port
module dpram_port_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter int                NUM_REQ   = 3,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 10,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      ram_wren,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [DATA_W-1:0]         ram_data,
  input  logic [DATA_W-1:0]         ram_q
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'((2 ** ADDR_W) - 1);

  arb_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clear_busy_q, clear_busy_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;

  logic                arb_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [2:0]          win_idx;
  logic                in_clear;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;

  // The pointer must not move while clearing, and reset_n gating keeps ack
  // low during reset even though the grant path is purely combinational.
  assign in_clear = (state_q == ST_CLEAR);
  assign arb_en   = reset_n && !in_clear;

  dpram_port_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (arb_en),
    .req     (req),
    .gnt     (gnt),
    .win_idx (win_idx)
  );

  // Winner's fields; with no request win_idx is the previous winner.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 3'(i)) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_we    = we[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // Counter wraps to zero on the same edge that returns to IDLE.
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    clear_busy_d = (state_d == ST_CLEAR);
    // A read granted alongside clear_start still returns in CLEAR cycle 1.
    rvalid_d     = gnt & ~we;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      clear_busy_q <= 1'b0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clear_busy_q <= clear_busy_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign ack         = gnt;
  assign rvalid      = rvalid_q;
  assign rdata       = ram_q;
  assign clear_busy  = clear_busy_q;
  assign ram_wren    = reset_n && (in_clear || ((|gnt) && sel_we));
  assign ram_address = in_clear ? clr_cnt_q : sel_addr;
  assign ram_data    = in_clear ? CLEAR_VAL : sel_wdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - self-checking bench for dpram_port_arbiter
module tb_dpram_port_arbiter;

  localparam int N     = 3;
  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req, we, ack, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          clear_start, clear_busy;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data, ram_q;

  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;

  int tests = 0;
  int fails = 0;

  dpram_port_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .CLEAR_VAL ('0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q)
  );

  always #5 clock = ~clock;

  // RAM port with registered q; pre_we is a bench-only preload path.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clock) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (ram_wren) ram[ram_address] <= ram_data;
    ram_q <= ram[ram_address];
  end

  // Reference model: expected RAM contents, rotating pointer, clear progress.
  logic [DW-1:0] mmem [0:DEPTH-1];
  int            m_last;
  bit            m_clr;
  int            m_cnt;
  logic [N-1:0]  m_rv;
  logic [DW-1:0] m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_clr  = 0;
    m_cnt  = 0;
    m_rv   = '0;
    m_rd   = '0;
  endtask

  // Compare DUT outputs with the model for the current cycle, then advance
  // the model across the coming rising edge using the inputs now applied.
  task automatic model_step();
    int w;
    int a;
    logic [N-1:0] exp_ack;
    if (!reset_n) begin
      chk("rst_ack", 32'(ack), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_busy", 32'(clear_busy), 0);
      chk("rst_wren", 32'(ram_wren), 0);
      if (pre_we) mmem[pre_a] = pre_d;
      model_reset();
      return;
    end
    w = -1;
    exp_ack = '0;
    if (!m_clr) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (req[i] && w < 0) w = i;
      end
    end
    if (w >= 0) exp_ack[w] = 1'b1;
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("clear_busy", 32'(clear_busy), 32'(m_clr));
    chk("rvalid", 32'(rvalid), 32'(m_rv));
    if (m_rv != 0) chk("rdata", 32'(rdata), 32'(m_rd));
    if (m_clr) begin
      chk("clr_wren", 32'(ram_wren), 1);
      chk("clr_addr", 32'(ram_address), 32'(m_cnt));
      chk("clr_data", 32'(ram_data), 0);
    end else if (w >= 0) begin
      chk("grant_wren", 32'(ram_wren), 32'(we[w]));
      chk("grant_addr", 32'(ram_address), 32'(addr[w*AW +: AW]));
      if (we[w]) chk("grant_data", 32'(ram_data), 32'(wdata[w*DW +: DW]));
    end else begin
      chk("idle_wren", 32'(ram_wren), 0);
    end
    m_rv = '0;
    if (w >= 0) begin
      a = int'(addr[w*AW +: AW]);
      if (we[w]) mmem[a] = wdata[w*DW +: DW];
      else begin
        m_rv[w] = 1'b1;
        m_rd = mmem[a];
      end
      m_last = w;
    end
    if (m_clr) begin
      mmem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_clr = 0;
        m_cnt = 0;
      end
    end else if (clear_start) begin
      m_clr = 1;
    end
  endtask

  task automatic sample();
    @(negedge clock);
    model_step();
  endtask

  task automatic cyc_end();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  logic [N-1:0] exp_seq [4];

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    model_reset();
    reset_n = 0; req = 3'b111; we = '0; addr = '0; wdata = '0;
    clear_start = 0; pre_we = 1; pre_a = 10'h010; pre_d = 16'hBEEF;
    #1;
    // Reset state with requests present
    sample();
    chk("reset_ack_lit", 32'(ack), 0);
    chk("reset_busy_lit", 32'(clear_busy), 0);
    chk("reset_rvalid_lit", 32'(rvalid), 0);
    cyc_end();
    pre_we = 0; req = '0;
    sample(); cyc_end();

    // Single read
    reset_n = 1; req = 3'b001; addr[0 +: AW] = 10'h010;
    sample();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_wren", 32'(ram_wren), 0);
    chk("single_addr", 32'(ram_address), 32'h010);
    cyc_end();
    req = '0;
    sample();
    chk("single_rvalid", 32'(rvalid), 32'h1);
    chk("single_rdata", 32'(rdata), 32'hBEEF);
    cyc_end();

    // Contention from a fresh reset
    reset_n = 0;
    sample(); cyc_end();
    reset_n = 1; req = 3'b111; we = '0;
    addr = {10'h3FF, 10'h011, 10'h010};
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("rr_ack", 32'(ack), 32'(exp_seq[i]));
      if (i > 0) chk("rr_rvalid", 32'(rvalid), 32'(exp_seq[i-1]));
      cyc_end();
    end
    req = '0;
    sample();
    chk("rr_rvalid_last", 32'(rvalid), 32'h1);
    cyc_end();

    // Write then read on consecutive cycles
    req = 3'b100; we = 3'b100; addr[2*AW +: AW] = 10'h3FF; wdata[2*DW +: DW] = 16'h1234;
    sample();
    chk("wr_ack", 32'(ack), 32'h4);
    chk("wr_wren", 32'(ram_wren), 1);
    cyc_end();
    req = 3'b010; we = '0; addr[AW +: AW] = 10'h3FF;
    sample();
    chk("rd_ack", 32'(ack), 32'h2);
    cyc_end();
    req = '0;
    sample();
    chk("wr_rd_rvalid", 32'(rvalid), 32'h2);
    chk("wr_rd_rdata", 32'(rdata), 32'h1234);
    cyc_end();

    // Full clear with a requester held pending
    clear_start = 1;
    sample(); cyc_end();
    clear_start = 0; req = 3'b010; addr[AW +: AW] = 10'h010;
    n = 0;
    for (int c = 0; c < 1100; c++) begin
      sample();
      if (!clear_busy) break;
      n++;
      if (n == 1) chk("clr_first_addr", 32'(ram_address), 0);
      if (n == 1024) chk("clr_last_addr", 32'(ram_address), 32'h3FF);
      cyc_end();
    end
    chk("clr_len", 32'(n), 1024);
    chk("clr_pending_ack", 32'(ack), 32'h2);
    cyc_end();
    req = '0;
    sample();
    chk("clr_readback", 32'(rdata), 0);
    cyc_end();

    // Clear and read grant in the same cycle; re-trigger ignored
    req = 3'b100; we = 3'b100; wdata[2*DW +: DW] = 16'h5A5A;
    sample(); cyc_end();
    we = '0; clear_start = 1;
    sample();
    chk("coll_ack", 32'(ack), 32'h4);
    cyc_end();
    clear_start = 0; req = '0;
    sample();
    chk("coll_rvalid", 32'(rvalid), 32'h4);
    chk("coll_rdata", 32'(rdata), 32'h5A5A);
    chk("coll_busy", 32'(clear_busy), 1);
    n = 1;
    cyc_end();
    for (int c = 0; c < 1100; c++) begin
      clear_start = (n == 499);
      sample();
      if (!clear_busy) break;
      n++;
      cyc_end();
    end
    chk("coll_len", 32'(n), 1024);
    cyc_end();
    clear_start = 0;
    sample(); cyc_end();

    // Reset in the middle of a clear
    clear_start = 1;
    sample(); cyc_end();
    clear_start = 0; req = 3'b001;
    for (int c = 1; c < 200; c++) begin
      sample(); cyc_end();
    end
    reset_n = 0;
    #1;
    chk("mid_rst_busy", 32'(clear_busy), 0);
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    sample(); cyc_end();
    sample(); cyc_end();
    reset_n = 1; req = 3'b111;
    sample();
    chk("post_rst_ack", 32'(ack), 32'h1);
    chk("post_rst_busy", 32'(clear_busy), 0);
    cyc_end();
    req = '0;
    sample(); cyc_end();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
